// File: rtl/la_capture_ctrl.sv
// -----------------------------------------------------------------------------
// la_capture_ctrl
// Logic-analyser capture engine. It samples the probe bus on every clock and
// run-length encodes the samples into memory lines of {reps, data}.
// Pre-trigger history goes into a circular ring at addresses 0..BT-1.
// Post-trigger lines go linearly from address BT up to 2^AW-2.
// The last line (2^AW-1) holds the ring tail pointer, so the reader can
// unroll the ring in chronological order.
//
// Ports
//   clk_of_verifla      in   1      single clock, rising edge
//   rst_l               in   1      asynchronous active-low reset
//   arm                 in   1      start-capture pulse (accepted in IDLE/DONE)
//   data_in             in   DW     probe bus
//   mem_we              out  1      memory write strobe, one line per cycle
//   mem_addr            out  AW     memory write address
//   mem_wdata           out  RW+DW  {reps, data}
//   la_trigger_matched  out  1      high from trigger sample until next arm
//   capture_busy        out  1      high while capturing (PRE/POST/WR_TAIL)
//   done                out  1      high once the tail line has been issued
// -----------------------------------------------------------------------------
module la_capture_ctrl #(
  parameter int                       LA_DATA_WIDTH     = 16,
  parameter int                       LA_REPS_WIDTH     = 8,
  parameter int                       LA_MEM_ADDR_WIDTH = 6,
  parameter int                       LA_BT_QUEUE_SIZE  = 8,
  parameter logic [LA_DATA_WIDTH-1:0] LA_TRIGGER_VALUE  = 16'h0204,
  parameter logic [LA_DATA_WIDTH-1:0] LA_TRIGGER_MASK   = 16'hFFFF
) (
  input  logic                                   clk_of_verifla,
  input  logic                                   rst_l,
  input  logic                                   arm,
  input  logic [LA_DATA_WIDTH-1:0]               data_in,
  output logic                                   mem_we,
  output logic [LA_MEM_ADDR_WIDTH-1:0]           mem_addr,
  output logic [LA_REPS_WIDTH+LA_DATA_WIDTH-1:0] mem_wdata,
  output logic                                   la_trigger_matched,
  output logic                                   capture_busy,
  output logic                                   done
);

  localparam int DW = LA_DATA_WIDTH;
  localparam int RW = LA_REPS_WIDTH;
  localparam int AW = LA_MEM_ADDR_WIDTH;

  localparam logic [RW-1:0] REPS_MAX       = {RW{1'b1}};
  localparam logic [RW-1:0] REPS_ONE       = RW'(1);
  localparam logic [AW-1:0] ADDR_ONE       = AW'(1);
  localparam logic [AW-1:0] ADDR_ZERO      = AW'(0);
  localparam logic [AW-1:0] ADDR_RING_LAST = AW'(LA_BT_QUEUE_SIZE - 1);
  localparam logic [AW-1:0] ADDR_BT        = AW'(LA_BT_QUEUE_SIZE);
  localparam logic [AW-1:0] ADDR_TAIL      = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_POST_LAST = ADDR_TAIL - ADDR_ONE;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_POST    = 3'd2,
    ST_WR_TAIL = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_run_valid;     // a run is being held
  logic [DW-1:0]    r_run_data;
  logic [RW-1:0]    r_run_reps;
  logic [AW-1:0]    r_ring_addr;     // next ring address to write
  logic [AW-1:0]    r_tail_addr;     // last ring address written
  logic             r_ring_written;  // at least one ring line this capture
  logic [AW-1:0]    r_post_addr;     // next post-trigger address to write
  logic             r_mem_we;
  logic [AW-1:0]    r_mem_addr;
  logic [RW+DW-1:0] r_mem_wdata;
  logic             r_trig;
  logic             r_busy;
  logic             r_done;

  logic             w_trig_hit;
  logic             w_extend;
  logic [AW-1:0]    w_ring_next;
  logic [DW-1:0]    w_tail_data;

  // Run bookkeeping: the held run grows while the sample repeats and the
  // counter is not yet saturated; anything else closes the run.
  always_comb begin
    w_trig_hit  = ((data_in & LA_TRIGGER_MASK) == (LA_TRIGGER_VALUE & LA_TRIGGER_MASK));
    w_extend    = 1'b0;
    w_ring_next = r_ring_addr + ADDR_ONE;
    w_tail_data = {DW{1'b1}};
    if (r_run_valid && (data_in == r_run_data) && (r_run_reps != REPS_MAX)) begin
      w_extend = 1'b1;
    end else begin
      w_extend = 1'b0;
    end
    if (r_ring_addr == ADDR_RING_LAST) begin
      w_ring_next = ADDR_ZERO;
    end else begin
      w_ring_next = r_ring_addr + ADDR_ONE;
    end
    // No ring line this capture is flagged to the reader with all ones.
    if (r_ring_written) begin
      w_tail_data = DW'(r_tail_addr);
    end else begin
      w_tail_data = {DW{1'b1}};
    end
  end

  // Capture state machine with registered memory-port and status outputs.
  always_ff @(posedge clk_of_verifla or negedge rst_l) begin
    if (!rst_l) begin
      r_state        <= ST_IDLE;
      r_run_valid    <= 1'b0;
      r_run_data     <= '0;
      r_run_reps     <= '0;
      r_ring_addr    <= '0;
      r_tail_addr    <= '0;
      r_ring_written <= 1'b0;
      r_post_addr    <= ADDR_BT;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_trig         <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            r_state        <= ST_PRE;
            r_run_valid    <= 1'b0;
            r_run_reps     <= '0;
            r_ring_addr    <= '0;
            r_tail_addr    <= '0;
            r_ring_written <= 1'b0;
            r_post_addr    <= ADDR_BT;
            r_trig         <= 1'b0;
            r_busy         <= 1'b1;
            r_done         <= 1'b0;
          end
        end

        ST_PRE: begin
          if (w_trig_hit) begin
            // Flush whatever pre-trigger run is pending, then restart the
            // run on the trigger sample so it always opens the post region.
            if (r_run_valid) begin
              r_mem_we       <= 1'b1;
              r_mem_addr     <= r_ring_addr;
              r_mem_wdata    <= {r_run_reps, r_run_data};
              r_tail_addr    <= r_ring_addr;
              r_ring_written <= 1'b1;
              r_ring_addr    <= w_ring_next;
            end
            r_run_valid <= 1'b1;
            r_run_data  <= data_in;
            r_run_reps  <= REPS_ONE;
            r_trig      <= 1'b1;
            r_state     <= ST_POST;
          end else if (w_extend) begin
            r_run_reps <= r_run_reps + REPS_ONE;
          end else begin
            if (r_run_valid) begin
              r_mem_we       <= 1'b1;
              r_mem_addr     <= r_ring_addr;
              r_mem_wdata    <= {r_run_reps, r_run_data};
              r_tail_addr    <= r_ring_addr;
              r_ring_written <= 1'b1;
              r_ring_addr    <= w_ring_next;
            end
            r_run_valid <= 1'b1;
            r_run_data  <= data_in;
            r_run_reps  <= REPS_ONE;
          end
        end

        ST_POST: begin
          if (w_extend) begin
            r_run_reps <= r_run_reps + REPS_ONE;
          end else begin
            if (r_run_valid) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_post_addr;
              r_mem_wdata <= {r_run_reps, r_run_data};
              // The run still open when the region fills is dropped.
              if (r_post_addr == ADDR_POST_LAST) begin
                r_state <= ST_WR_TAIL;
              end else begin
                r_post_addr <= r_post_addr + ADDR_ONE;
              end
            end
            r_run_valid <= 1'b1;
            r_run_data  <= data_in;
            r_run_reps  <= REPS_ONE;
          end
        end

        ST_WR_TAIL: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= ADDR_TAIL;
          r_mem_wdata <= {{RW{1'b0}}, w_tail_data};
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_state     <= ST_DONE;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we             = r_mem_we;
  assign mem_addr           = r_mem_addr;
  assign mem_wdata          = r_mem_wdata;
  assign la_trigger_matched = r_trig;
  assign capture_busy       = r_busy;
  assign done               = r_done;

endmodule

// File: tb/tb_la_capture_ctrl.sv
module tb_la_capture_ctrl;

  localparam logic [23:0] SENT = 24'hDEADBE;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        arm = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [23:0] mem_wdata;
  logic        trig;
  logic        busy;
  logic        done;

  logic        arm_m = 1'b0;
  logic [15:0] data_m = 16'h0000;
  logic        mem_we_m;
  logic [5:0]  mem_addr_m;
  logic [23:0] mem_wdata_m;
  logic        trig_m;
  logic        busy_m;
  logic        done_m;

  logic [23:0] mem [0:63];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  la_capture_ctrl u_dut (
    .clk_of_verifla     (clk),
    .rst_l              (rst_l),
    .arm                (arm),
    .data_in            (data_in),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .la_trigger_matched (trig),
    .capture_busy       (busy),
    .done               (done)
  );

  la_capture_ctrl #(
    .LA_TRIGGER_VALUE (16'h0004),
    .LA_TRIGGER_MASK  (16'h00FF)
  ) u_dut_m (
    .clk_of_verifla     (clk),
    .rst_l              (rst_l),
    .arm                (arm_m),
    .data_in            (data_m),
    .mem_we             (mem_we_m),
    .mem_addr           (mem_addr_m),
    .mem_wdata          (mem_wdata_m),
    .la_trigger_matched (trig_m),
    .capture_busy       (busy_m),
    .done               (done_m)
  );

  // Sample memory model
  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
  end

  function automatic logic [15:0] cnt_val(input int c);
    logic [7:0] lo;
    lo = c[7:0];
    return {lo >> 1, lo};
  endfunction

  task automatic step(input logic [15:0] v);
    data_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) mem[i] = SENT;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
  endtask

  // Feed distinct values until done (bounded), then one more edge so the
  // tail line lands in the model.
  task automatic finish_run(input logic [15:0] base);
    for (int i = 0; i < 120 && done !== 1'b1; i++) step(base + 16'(i));
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL finish_timeout: done=%b required 1", done);
    end
    step(base);
    checks++;
    if ({mem_we, busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_idle: we,busy=%b required 00", {mem_we, busy});
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, trig, busy, done} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {mem_we, mem_addr, mem_wdata, trig, busy, done});
    end
    rst_l = 1'b1;
    step(16'h0204);
    step(16'h0205);
    checks++;
    if ({mem_we, trig, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_no_arm: we,trig,busy,done=%b required 0000", {mem_we, trig, busy, done});
    end
  endtask

  task automatic test_count();
    clear_model();
    do_arm();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL arm_busy: busy=%b required 1", busy);
    end
    for (int s = 0; s < 120 && done !== 1'b1; s++) begin
      step(cnt_val(s));
      if (s == 0) begin
        checks++;
        if (mem_we !== 1'b0) begin
          errors++;
          $display("FAIL first_sample_nowrite: we=%b required 0", mem_we);
        end
      end
      if (s == 1) begin
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd0, 24'h010000}) begin
          errors++;
          $display("FAIL run_end_timing: got %b/%0d/%h required 1/0/010000", mem_we, mem_addr, mem_wdata);
        end
      end
      if (s == 3) begin
        checks++;
        if (trig !== 1'b0) begin
          errors++;
          $display("FAIL early_trigger: trig=%b required 0", trig);
        end
      end
      if (s == 4) begin
        checks++;
        if ({trig, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 6'd3, 24'h010103}) begin
          errors++;
          $display("FAIL trigger_flush: got %b/%b/%0d/%h required 1/1/3/010103", trig, mem_we, mem_addr, mem_wdata);
        end
      end
    end
    checks++;
    if ({done, busy, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 6'd63, 24'h000003}) begin
      errors++;
      $display("FAIL tail_write: got d%b b%b %b/%0d/%h required d1 b0 1/63/000003", done, busy, mem_we, mem_addr, mem_wdata);
    end
    step(16'h7777);
    checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== {24'h010000, 24'h010001, 24'h010102, 24'h010103}) begin
      errors++;
      $display("FAIL ring_lines: got %h %h %h %h", mem[0], mem[1], mem[2], mem[3]);
    end
    checks++;
    if ({mem[8], mem[9], mem[62], mem[63]} !== {24'h010204, 24'h010205, 24'h011D3A, 24'h000003}) begin
      errors++;
      $display("FAIL post_lines: got %h %h %h %h required 010204 010205 011D3A 000003", mem[8], mem[9], mem[62], mem[63]);
    end
    checks++;
    if ({mem_we, trig, done} !== 3'b011) begin
      errors++;
      $display("FAIL done_state: we,trig,done=%b required 011", {mem_we, trig, done});
    end
  endtask

  task automatic test_saturation();
    clear_model();
    do_arm();
    repeat (300) step(16'h0011);
    step(16'h0022);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd1, 24'h2D0011}) begin
      errors++;
      $display("FAIL sat_remainder: got %b/%0d/%h required 1/1/2D0011", mem_we, mem_addr, mem_wdata);
    end
    // arm while capturing must not restart the ring
    arm = 1'b1;
    step(16'h0033);
    arm = 1'b0;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, busy} !== {1'b1, 6'd2, 24'h010022, 1'b1}) begin
      errors++;
      $display("FAIL arm_ignored: got %b/%0d/%h busy %b required 1/2/010022 busy 1", mem_we, mem_addr, mem_wdata, busy);
    end
    step(16'h0033);
    checks++;
    if ({mem[0], mem[1], trig} !== {24'hFF0011, 24'h2D0011, 1'b0}) begin
      errors++;
      $display("FAIL sat_lines: got %h %h trig %b required FF0011 2D0011 trig 0", mem[0], mem[1], trig);
    end
    rst_l = 1'b0;
    #2;
    rst_l = 1'b1;
  endtask

  task automatic test_ring_wrap();
    clear_model();
    do_arm();
    for (int i = 1; i <= 10; i++) step(16'h1000 + 16'(i));
    step(16'h0204);
    checks++;
    if ({trig, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 6'd1, 24'h01100A}) begin
      errors++;
      $display("FAIL wrap_flush: got %b/%b/%0d/%h required 1/1/1/01100A", trig, mem_we, mem_addr, mem_wdata);
    end
    finish_run(16'h3000);
    checks++;
    if ({mem[0], mem[1], mem[2], mem[7]} !== {24'h011009, 24'h01100A, 24'h011003, 24'h011008}) begin
      errors++;
      $display("FAIL wrap_lines: got %h %h %h %h required 011009 01100A 011003 011008", mem[0], mem[1], mem[2], mem[7]);
    end
    checks++;
    if ({mem[8], mem[63]} !== {24'h010204, 24'h000001}) begin
      errors++;
      $display("FAIL wrap_tail: got %h %h required 010204 000001", mem[8], mem[63]);
    end
  endtask

  task automatic test_first_trigger();
    clear_model();
    do_arm();
    step(16'h0204);
    checks++;
    if ({trig, mem_we} !== 2'b10) begin
      errors++;
      $display("FAIL first_trig: trig,we=%b required 10", {trig, mem_we});
    end
    step(16'h5000);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd8, 24'h010204}) begin
      errors++;
      $display("FAIL first_trig_line: got %b/%0d/%h required 1/8/010204", mem_we, mem_addr, mem_wdata);
    end
    finish_run(16'h5001);
    checks++;
    if ({mem[63], mem[0], mem[7]} !== {24'h00FFFF, SENT, SENT}) begin
      errors++;
      $display("FAIL no_ring_tail: got %h %h %h required 00FFFF %h %h", mem[63], mem[0], mem[7], SENT, SENT);
    end
  endtask

  task automatic test_async_reset();
    do_arm();
    step(16'h0204);
    step(16'h0300);
    step(16'h0301);
    #2;
    rst_l = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, trig, busy, done} !== 34'd0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0", {mem_we, mem_addr, mem_wdata, trig, busy, done});
    end
    #1;
    rst_l = 1'b1;
    step(16'h0400);
    step(16'h0401);
    checks++;
    if ({mem_we, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_to_idle: we,busy=%b required 00", {mem_we, busy});
    end
    clear_model();
    do_arm();
    step(16'h0100);
    step(16'h0101);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 6'd0, 24'h010100}) begin
      errors++;
      $display("FAIL rearm_ring0: got %b/%0d/%h required 1/0/010100", mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_mask();
    arm_m = 1'b1;
    @(posedge clk);
    #1;
    arm_m = 1'b0;
    data_m = 16'h0705;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({trig_m, busy_m} !== 2'b01) begin
      errors++;
      $display("FAIL mask_nomatch: trig,busy=%b required 01", {trig_m, busy_m});
    end
    data_m = 16'h0704;
    @(posedge clk);
    #1;
    checks++;
    if ({trig_m, busy_m} !== 2'b11) begin
      errors++;
      $display("FAIL mask_match: trig,busy=%b required 11", {trig_m, busy_m});
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_saturation();
    test_ring_wrap();
    test_first_trigger();
    test_async_reset();
    test_mask();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
